mul_seq_ctrl: RTL

- Sequencer for the multi-cycle multiply operation (ALU control code 3'b011) in the EX stage of the 5-stage MIPS pipeline.
- Accepts operands when EX decodes a mul and runs an iterative shift-add multiply for DATA_W cycles.
- Holds the pipeline via stall_o, then presents the low DATA_W bits of the product for one cycle with done_o.
- Every other ALU control code bypasses this block entirely.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/mul_seq_ctrl.sv | 62 ++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: ALU control codes and multiply-sequencer state encoding
package cpu_pkg;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_BUSY = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;
endpackage

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: iterative shift-add multiply sequencer for EX; MUL_SEQ_EARLY_EXIT_EN ends once the multiplier runs out of set bits
module mul_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [2:0]        ALUCtrl_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o
);
  ms_state_e         state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] a_in, m_in, p_in;
  logic              accept, step, last;
  // The first iteration runs in the accept cycle on the raw operands, so DONE lands exactly DATA_W cycles after accept
  always_comb begin
    accept   = start_i && ALUCtrl_i == ALU_MUL && state_q == MS_IDLE && !flush_i;
    step     = accept || (state_q == MS_BUSY && !flush_i);
    a_in     = accept ? '0 : acc_q;
    m_in     = accept ? src1_i : mcand_q;
    p_in     = accept ? src2_i : mplier_q;
    last     = !accept && cnt_q == CNT_W'(DATA_W - 1);
`ifdef MUL_SEQ_EARLY_EXIT_EN
    last     = last || (p_in >> 1) == '0;
`endif
    acc_d    = step ? (p_in[0] ? a_in + m_in : a_in) : acc_q;
    mcand_d  = step ? m_in << 1 : mcand_q;
    mplier_d = step ? p_in >> 1 : mplier_q;
    cnt_d    = accept ? CNT_W'(1) : step ? cnt_q + 1'b1 : cnt_q;
    state_d  = step ? (last ? MS_DONE : MS_BUSY) : (flush_i || state_q == MS_DONE) ? MS_IDLE : state_q;
    stall_o  = step;
    busy_o   = state_q != MS_IDLE;
    done_o   = state_q == MS_DONE && !flush_i;
    result_o = acc_q;
  end
  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= MS_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule
